// File: rtl/psum_drain.sv
// Accumulator drain: snapshots the SIZE x SIZE accumulator array on load, rounds/ReLUs/saturates
// each element to DATA_WID bits, then streams one row per valid/ready beat.
module psum_drain #(
    parameter int DATA_WID = 16,
    parameter int SIZE     = 8,
    parameter int ACC_WID  = 48,
    parameter int ROW_WID  = $clog2(SIZE)
) (
    input  logic                                    clock,
    input  logic                                    rst_n,
    input  logic [SIZE-1:0][SIZE-1:0][ACC_WID-1:0]  acc_in,
    input  logic                                    load_i,
    input  logic [5:0]                              shift_i,
    input  logic                                    relu_en_i,
    output logic                                    busy_o,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [SIZE-1:0][DATA_WID-1:0]           out_data_o,
    output logic [ROW_WID-1:0]                      out_row_o,
    output logic                                    out_last_o,
    output logic                                    sat_o
);

    // state | meaning
    // IDLE  | no frame held, waiting for load_i
    // DRAIN | frame held, presenting row r_row
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [ROW_WID-1:0]      LAST_ROW = ROW_WID'(SIZE - 1);
    localparam logic signed [ACC_WID:0] W_ONE    = (ACC_WID+1)'(1);
    localparam logic signed [ACC_WID:0] SAT_MAX  =
        {{(ACC_WID-DATA_WID+2){1'b0}}, {(DATA_WID-1){1'b1}}};
    localparam logic signed [ACC_WID:0] SAT_MIN  = ~SAT_MAX;

    logic [0:0]                                r_state;
    logic [ROW_WID-1:0]                        r_row;
    logic [SIZE-1:0][SIZE-1:0][DATA_WID-1:0]   r_buf;
    logic                                      r_sat;

    logic [SIZE-1:0][SIZE-1:0][DATA_WID:0]     w_res;
    logic [SIZE-1:0][SIZE-1:0][DATA_WID-1:0]   w_conv;
    logic                                      w_sat_any;
    logic                                      w_fire;
    logic                                      w_last_fire;
    logic                                      w_load_acc;

    // Returns {clipped, value}; the ACC_WID+1 working width keeps the rounding add from overflowing.
    function automatic logic [DATA_WID:0] f_convert(
        input logic [ACC_WID-1:0] a,
        input logic [5:0]         s,
        input logic               relu
    );
        logic signed [ACC_WID:0] v_ext;
        logic signed [ACC_WID:0] v_half;
        logic signed [ACC_WID:0] v_rnd;
        logic [DATA_WID-1:0]     v_out;
        logic                    v_sat;
        v_ext  = signed'({a[ACC_WID-1], a});
        v_half = W_ONE <<< (s - 6'd1);
        if (s == 6'd0) begin
            v_rnd = v_ext;
        end else begin
            v_rnd = (v_ext + v_half) >>> s;
        end
        if (relu && v_rnd[ACC_WID]) begin
            v_rnd = '0;
        end
        v_sat = 1'b0;
        if (v_rnd > SAT_MAX) begin
            v_out = SAT_MAX[DATA_WID-1:0];
            v_sat = 1'b1;
        end else if (v_rnd < SAT_MIN) begin
            v_out = SAT_MIN[DATA_WID-1:0];
            v_sat = 1'b1;
        end else begin
            v_out = v_rnd[DATA_WID-1:0];
        end
        return {v_sat, v_out};
    endfunction

    always_comb begin
        w_res = '0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                w_res[r][c] = f_convert(acc_in[r][c], shift_i, relu_en_i);
            end
        end
    end

    always_comb begin
        w_conv    = '0;
        w_sat_any = 1'b0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                w_conv[r][c] = w_res[r][c][DATA_WID-1:0];
                w_sat_any    = w_sat_any | w_res[r][c][DATA_WID];
            end
        end
    end

    assign w_fire      = (r_state == ST_DRAIN) && out_ready_i;
    assign w_last_fire = w_fire && (r_row == LAST_ROW);
    assign w_load_acc  = load_i && ((r_state == ST_IDLE) || w_last_fire);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_buf   <= '0;
            r_sat   <= 1'b0;
        end else if (w_load_acc) begin
            r_state <= ST_DRAIN;
            r_row   <= '0;
            r_buf   <= w_conv;
            r_sat   <= w_sat_any;
        end else if (w_fire) begin
            if (r_row == LAST_ROW) begin
                r_state <= ST_IDLE;
                r_row   <= '0;
            end else begin
                r_row   <= r_row + 1'b1;
            end
        end
    end

    assign busy_o      = (r_state == ST_DRAIN);
    assign out_valid_o = (r_state == ST_DRAIN);
    assign out_data_o  = r_buf[r_row];
    assign out_row_o   = r_row;
    assign out_last_o  = (r_row == LAST_ROW) && out_valid_o;
    assign sat_o       = r_sat;

endmodule

// File: doc/psum_drain.md
# psum_drain

Output-side drain for the compute cube. On a load pulse it snapshots the SIZE×SIZE array of 48-bit signed accumulators, converting each element to DATA_WID bits using a rounding right shift, optional ReLU and signed saturation. It then streams the frame out one row per beat over a valid/ready interface toward the output buffer or writeback path. This block is the consumer end of the cube's accumulator interface.

## Interface
- DATA_WID, 16, output element width (signed)
- SIZE, 8, array dimension; rows per frame and elements per row
- ACC_WID, 48, accumulator element width (signed two's complement)
- ROW_WID, $clog2(SIZE), row index width
- clock  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- acc_in  in  ACC_WID × [SIZE][SIZE]  accumulator array from the cube, indexed [row][col]
- load_i  in  1  capture request for acc_in
- shift_i  in  6  right-shift amount, 0..47; sampled on accepted load
- relu_en_i  in  1  clamp negatives to 0; sampled on accepted load
- busy_o  out  1  frame held, not fully drained
- out_valid_o  out  1  row beat valid
- out_ready_i  in  1  downstream accepts beat
- out_data_o  out  DATA_WID × [SIZE]  converted row, [col]
- out_row_o  out  ROW_WID  row index of current beat
- out_last_o  out  1  current beat is row SIZE-1
- sat_o  out  1  some element of the current frame saturated

## Operation
- FSM states:
  - IDLE: busy_o=0, out_valid_o=0.
  - DRAIN: busy_o=1, out_valid_o=1.
- Load acceptance: load_i is accepted when state=IDLE, or in DRAIN in the cycle of the final handshake (out_valid_o & out_ready_i & out_last_o). load_i in any other cycle is ignored, with no side effects. Upstream must check busy_o.
- On accepted load, all SIZE×SIZE elements are converted combinationally from acc_in and written into the frame buffer (SIZE×SIZE×DATA_WID registers). sat_o is updated, the row counter is set to 0, and the next state is DRAIN.
- Conversion per element, with a signed and s = shift_i:
  - If s>0, r = (a + 2^(s-1)) >>> s, computed at ACC_WID+1 bits so the add cannot overflow. If s=0, r = a.
  - If relu_en_i=1 and r<0, r = 0.
  - Saturate r to [-2^(DATA_WID-1), 2^(DATA_WID-1)-1]. sat_o = OR over all elements whose value was clipped by this saturation step. ReLU clamping does not set sat_o.
- Beat outputs:
  - out_data_o = buffer[row]
  - out_row_o = row
  - out_last_o = (row==SIZE-1) & out_valid_o
- Handshake: a beat transfers when out_valid_o & out_ready_i. The row counter then increments. After the last beat, the next state is IDLE, or DRAIN with row 0 if a load was accepted in that cycle.
- While out_valid_o=1 and out_ready_i=0, out_data_o, out_row_o and out_last_o hold stable and out_valid_o stays high. Valid never drops without a transfer.
- The frame buffer is written only on accepted loads. acc_in changes during DRAIN have no effect.

## Timing
- Reset values: busy_o=0, out_valid_o=0, out_row_o=0, out_last_o=0, out_data_o=0 (buffer cleared), sat_o=0, state IDLE.
- Reset mid-drain aborts the frame. All outputs take their reset values at the next edge and no further beats are produced.
- Load-to-first-beat latency is 1 cycle: load accepted at edge t gives out_valid_o=1 with row 0 after edge t.
- With out_ready_i held high, SIZE beats arrive on SIZE consecutive cycles and the frame occupies SIZE cycles.
- Back-to-back frames with no bubble: with load_i asserted on the last handshake and out_ready_i held high, a new frame starts every SIZE cycles.
- sat_o updates on the same edge as the buffer and holds until the next accepted load.
- out_ready_i may be asserted before out_valid_o. This has no effect in IDLE.

## Test plan
- Basic drain: acc_in[r][c] = 256·(8r+c), shift=8, relu=0, ready=1 → 8 beats on consecutive cycles; row r data = {8r..8r+7}; out_last_o only on row 7; sat_o=0; busy_o low the cycle after beat 7.
- Rounding and ReLU: shift=2, elements 5, 6, -5, -6 → 1, 2, -1, -1. The same inputs with relu=1 → 1, 2, 0, 0, with sat_o=0.
- Saturation: shift=0, elements 40000, -40000, 32767 → 32767, -32768, 32767, and sat_o=1. A following frame with all values in range → sat_o=0.
- Backpressure: ready toggles 1,0,0,1,... → data and row stable during stalls; exactly 8 transfers; no duplicated or skipped rows.
- Load collisions: load_i pulsed mid-drain → ignored, frame unchanged. load_i on the row-7 handshake with a new acc_in → row 0 of the new frame appears the next cycle.
- Reset: rst_n low after beat 3 → next cycle all outputs 0. A subsequent load drains a full fresh frame starting at row 0.
